// File: rtl/c_dly_pkg.sv
// Shared constants and types for the 64-tap fine delay control loop.
package c_dly_pkg;
  localparam int TAPS   = 64;
  localparam int CODE_W = 7;
  localparam logic [CODE_W-1:0] CODE_MAX = 7'd64;

  // Signed accumulator spans +/-15 (max threshold), settle counter 1..255, reversals 1..15.
  localparam int ACC_W  = 5;
  localparam int SCNT_W = 8;
  localparam int REV_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACC    = 2'd2
  } st_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] c);
    return (c > CODE_MAX) ? CODE_MAX : c;
  endfunction
endpackage

// File: rtl/c_therm_enc64.sv
// Combinational code-to-thermometer encoder; codes above 64 saturate to all ones.
module c_therm_enc64
  import c_dly_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [TAPS-1:0]   sel_o
);
  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    assign sel_o[i] = (code_i > CODE_W'(i));
  end
endmodule

// File: rtl/c_dly_fine_ctrl.sv
// Bang-bang vote filter driving the fine delay code, with settle, saturation and lock tracking.
module c_dly_fine_ctrl
  import c_dly_pkg::*;
#(
  parameter int P_INIT     = 32,
  parameter int P_ACC_TH   = 4,
  parameter int P_SETTLE   = 8,
  parameter int P_LOCK_CNT = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
  input  logic              i_frz,
  input  logic              i_ld,
  input  logic [CODE_W-1:0] i_ld_code,
  input  logic              i_pd_vld,
  input  logic              i_pd_up,
  input  logic              i_pd_dn,
  output logic [TAPS-1:0]   o_sel,
  output logic [CODE_W-1:0] o_code,
  output logic              o_lock,
  output logic              o_sat_hi,
  output logic              o_sat_lo
);
  localparam logic [CODE_W-1:0]        INIT_C = CODE_W'(P_INIT);
  localparam logic signed [ACC_W-1:0]  ACC_TH = ACC_W'(P_ACC_TH);
  localparam logic signed [ACC_W-1:0]  ACC_ONE = ACC_W'(1);
  localparam logic [SCNT_W-1:0]        SETTLE_N = SCNT_W'(P_SETTLE);
  localparam logic [REV_W-1:0]         LOCK_N = REV_W'(P_LOCK_CNT);

  st_e                      st_q, st_d;
  dir_e                     dir_q, dir_d;
  logic [CODE_W-1:0]        code_q, code_d, enc_code;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_nx;
  logic [SCNT_W-1:0]        scnt_q, scnt_d;
  logic [REV_W-1:0]         rev_q, rev_d;
  logic                     lock_q, lock_d;
  logic [TAPS-1:0]          sel_q, sel_d;
  logic                     hi_q, lo_q;

  logic settle_last, vote_ok, up_v, dn_v, step_up, step_dn, blocked;

  // The last settle cycle already counts votes, so the first accepted vote
  // lands exactly P_SETTLE edges after the code change.
  assign settle_last = (st_q == ST_SETTLE) && (scnt_q == SCNT_W'(1));
  assign vote_ok     = ((st_q == ST_ACC) || settle_last) && i_pd_vld && !i_frz;
  assign up_v        = vote_ok && i_pd_up && !i_pd_dn;
  assign dn_v        = vote_ok && i_pd_dn && !i_pd_up;
  assign acc_nx      = up_v ? acc_q + ACC_ONE : (dn_v ? acc_q - ACC_ONE : acc_q);
  assign step_up     = up_v && (acc_nx == ACC_TH);
  assign step_dn     = dn_v && (acc_nx == -ACC_TH);
  assign blocked     = step_up ? (code_q == CODE_MAX) : (code_q == '0);

  always_comb begin
    st_d   = st_q;
    dir_d  = dir_q;
    code_d = code_q;
    acc_d  = acc_q;
    scnt_d = scnt_q;
    rev_d  = rev_q;
    lock_d = lock_q;
    if (i_ld) begin
      code_d = clamp_code(i_ld_code);
      acc_d  = '0;
      rev_d  = '0;
      lock_d = 1'b0;
      st_d   = i_en ? ST_SETTLE : ST_IDLE;
      scnt_d = SETTLE_N;
    end else if (!i_en) begin
      st_d   = ST_IDLE;
      acc_d  = '0;
      rev_d  = '0;
      lock_d = 1'b0;
    end else if (st_q == ST_IDLE) begin
      st_d   = ST_SETTLE;
      scnt_d = SETTLE_N;
    end else begin
      if (st_q == ST_SETTLE) begin
        scnt_d = scnt_q - SCNT_W'(1);
        if (settle_last) st_d = ST_ACC;
      end
      if (step_up || step_dn) begin
        acc_d = '0;
        dir_d = step_up ? DIR_UP : DIR_DN;
        if (blocked) begin
          rev_d  = '0;
          lock_d = 1'b0;
        end else begin
          code_d = step_up ? code_q + CODE_W'(1) : code_q - CODE_W'(1);
          st_d   = ST_SETTLE;
          scnt_d = SETTLE_N;
          if (dir_q != DIR_NONE && dir_q != dir_d) begin
            if (rev_q != LOCK_N) rev_d = rev_q + REV_W'(1);
            if (rev_d == LOCK_N) lock_d = 1'b1;
          end else begin
            rev_d  = '0;
            lock_d = 1'b0;
          end
        end
      end else begin
        acc_d = acc_nx;
      end
    end
  end

  // One encoder serves both reset and run so o_sel always tracks its code.
  assign enc_code = i_rstn ? code_d : INIT_C;

  c_therm_enc64 u_enc (
    .code_i (enc_code),
    .sel_o  (sel_d)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      st_q   <= ST_IDLE;
      dir_q  <= DIR_NONE;
      code_q <= INIT_C;
      acc_q  <= '0;
      scnt_q <= '0;
      rev_q  <= '0;
      lock_q <= 1'b0;
      sel_q  <= sel_d;
      hi_q   <= (INIT_C == CODE_MAX);
      lo_q   <= (INIT_C == '0);
    end else begin
      st_q   <= st_d;
      dir_q  <= dir_d;
      code_q <= code_d;
      acc_q  <= acc_d;
      scnt_q <= scnt_d;
      rev_q  <= rev_d;
      lock_q <= lock_d;
      sel_q  <= sel_d;
      hi_q   <= (code_d == CODE_MAX);
      lo_q   <= (code_d == '0);
    end
  end

  assign o_sel    = sel_q;
  assign o_code   = code_q;
  assign o_lock   = lock_q;
  assign o_sat_hi = hi_q;
  assign o_sat_lo = lo_q;
endmodule

// File: tb/tb_c_dly_fine_ctrl.sv
// Scoreboard bench for c_dly_fine_ctrl: directed plan plus biased random votes against a behavioural model.
module tb_c_dly_fine_ctrl;
  localparam int P_INIT = 32, P_ACC_TH = 4, P_SETTLE = 8, P_LOCK_CNT = 4;

  logic        clk = 1'b0;
  logic        rstn, en, frz, ld, vld, up, dn;
  logic [6:0]  ldc;
  logic [63:0] sel;
  logic [6:0]  code;
  logic        lock, hi, lo;

  c_dly_fine_ctrl #(
    .P_INIT(P_INIT), .P_ACC_TH(P_ACC_TH), .P_SETTLE(P_SETTLE), .P_LOCK_CNT(P_LOCK_CNT)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_frz(frz), .i_ld(ld), .i_ld_code(ldc),
    .i_pd_vld(vld), .i_pd_up(up), .i_pd_dn(dn),
    .o_sel(sel), .o_code(code), .o_lock(lock), .o_sat_hi(hi), .o_sat_lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  code;
    logic [63:0] sel;
    logic        lock, hi, lo;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, failures = 0;

  // Model: code/acc as integers, settling as "votes still to discard", active = loop enabled.
  int m_code, m_acc, m_rev, m_last, m_wait;
  bit m_lock, m_act;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, e, f, l, input logic [6:0] lc, input logic v, u, d);
    int a, dir;
    exp_t x;
    logic [63:0] ones;
    if (!r) begin
      m_code = P_INIT; m_acc = 0; m_rev = 0; m_last = 0; m_lock = 0; m_act = 0; m_wait = 0;
    end else if (l) begin
      m_code = (lc > 64) ? 64 : int'(lc);
      m_acc = 0; m_rev = 0; m_lock = 0; m_act = e; m_wait = P_SETTLE - 1;
    end else if (!e) begin
      m_act = 0; m_acc = 0; m_rev = 0; m_lock = 0;
    end else if (!m_act) begin
      m_act = 1; m_wait = P_SETTLE - 1;
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (v && !f && (u != d)) begin
      a = m_acc + (u ? 1 : -1);
      if (a == P_ACC_TH || a == -P_ACC_TH) begin
        m_acc = 0;
        dir = (a > 0) ? 1 : -1;
        if ((dir > 0 && m_code == 64) || (dir < 0 && m_code == 0)) begin
          m_rev = 0; m_lock = 0;
        end else begin
          m_code += dir;
          m_wait = P_SETTLE - 1;
          if (m_last == -dir) begin
            m_rev = (m_rev + 1 > P_LOCK_CNT) ? P_LOCK_CNT : m_rev + 1;
            if (m_rev == P_LOCK_CNT) m_lock = 1;
          end else begin
            m_rev = 0; m_lock = 0;
          end
        end
        m_last = dir;
      end else begin
        m_acc = a;
      end
    end
    ones   = '1;
    x.code = 7'(m_code);
    x.sel  = (m_code == 0) ? 64'd0 : (ones >> (64 - m_code));
    x.lock = m_lock;
    x.hi   = (m_code == 64);
    x.lo   = (m_code == 0);
    sbq.push_back(x);
  endtask

  task automatic cyc(input logic r, e, f, l, input logic [6:0] lc, input logic v, u, d);
    rstn = r; en = e; frz = f; ld = l; ldc = lc; vld = v; up = u; dn = d;
    model_step(r, e, f, l, lc, v, u, d);
    @(posedge clk);
    #2;
  endtask

  task automatic votes(input int n, input logic u, input logic d, input logic f);
    for (int i = 0; i < n; i++) cyc(1, 1, f, 0, 7'd0, 1, u, d);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, 7'd0, 0, 0, 0);
  endtask

  // Monitor: outputs are registered and valid every cycle; check each edge's result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_empty: no expected entry at %0t", $time);
      end else begin
        e = sbq.pop_front();
        cmp("sb_code", {57'd0, code}, {57'd0, e.code});
        cmp("sb_sel", sel, e.sel);
        cmp("sb_lock", {63'd0, lock}, {63'd0, e.lock});
        cmp("sb_sat_hi", {63'd0, hi}, {63'd0, e.hi});
        cmp("sb_sat_lo", {63'd0, lo}, {63'd0, e.lo});
      end
    end
  end

  initial begin
    int bias, left, r;
    logic rr, re, rf, rl, rv, ru, rd;
    logic [6:0] rc;
    cyc(0, 0, 0, 0, 7'd0, 0, 0, 0);
    cyc(0, 1, 1, 1, 7'd99, 1, 1, 0);
    cmp("rst_code", {57'd0, code}, 64'd32);
    cmp("rst_sel", sel, 64'h0000_0000_FFFF_FFFF);
    cmp("rst_flags", {61'd0, lock, hi, lo}, 64'd0);

    cyc(1, 1, 0, 0, 7'd0, 0, 0, 0);
    quiet(7);
    votes(4, 1, 0, 0);
    cmp("first_step", {57'd0, code}, 64'd33);
    votes(7, 1, 0, 0);
    cmp("settle_ignore", {57'd0, code}, 64'd33);

    votes(4, 0, 1, 0); quiet(7);
    votes(4, 1, 0, 0); quiet(7);
    votes(4, 0, 1, 0); quiet(7);
    votes(4, 1, 0, 0);
    cmp("lock_set", {63'd0, lock}, 64'd1);
    quiet(7);
    votes(4, 1, 0, 0);
    cmp("lock_clr", {63'd0, lock}, 64'd0);
    cmp("lock_clr_code", {57'd0, code}, 64'd34);
    quiet(7);
    votes(4, 1, 0, 0);

    cyc(1, 1, 0, 1, 7'd100, 0, 0, 0);
    cmp("ld_clamp", {57'd0, code}, 64'd64);
    cmp("ld_sel", sel, 64'hFFFF_FFFF_FFFF_FFFF);
    cmp("ld_sat_hi", {63'd0, hi}, 64'd1);
    quiet(7);
    votes(4, 1, 0, 0);
    votes(4, 1, 0, 0);
    cmp("sat_block", {57'd0, code}, 64'd64);
    cmp("sat_nolock", {63'd0, lock}, 64'd0);
    votes(4, 0, 1, 0);
    cmp("sat_no_settle", {57'd0, code}, 64'd63);

    quiet(7);
    votes(10, 1, 0, 1);
    cmp("frz_hold", {57'd0, code}, 64'd63);
    votes(3, 1, 0, 0);
    cmp("frz_acc0", {57'd0, code}, 64'd63);
    votes(1, 1, 0, 0);
    cmp("frz_release", {57'd0, code}, 64'd64);

    cyc(1, 0, 0, 1, 7'd5, 1, 1, 0);
    cmp("ld_en0", {57'd0, code}, 64'd5);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 7'd0, 1, 1, 0);
    cmp("idle_hold", {57'd0, code}, 64'd5);

    cyc(1, 1, 0, 1, 7'd0, 0, 0, 0);
    cmp("ld_zero_sel", sel, 64'd0);
    cmp("ld_sat_lo", {63'd0, lo}, 64'd1);
    quiet(3);
    cyc(0, 1, 0, 0, 7'd0, 1, 0, 1);
    cmp("rst_mid_settle", {57'd0, code}, 64'd32);

    bias = 1; left = 50;
    for (int n = 0; n < 4000; n++) begin
      if (left == 0) begin
        bias = ~bias & 1;
        left = $urandom_range(20, 300);
      end
      left--;
      rr = ($urandom_range(0, 999) >= 5);
      rl = ($urandom_range(0, 99) < 2);
      rc = 7'($urandom_range(0, 127));
      re = ($urandom_range(0, 99) >= 3);
      rf = ($urandom_range(0, 99) < 8);
      rv = ($urandom_range(0, 99) < 85);
      r  = $urandom_range(0, 99);
      ru = bias ? (r < 80) : (r < 20);
      r  = $urandom_range(0, 99);
      rd = bias ? (r < 20) : (r < 80);
      cyc(rr, re, rf, rl, rc, rv, ru, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
